tiny_alu_mc: RTL
================

TINY_ALU_MC -- requirements
Module: tiny_alu_mc

Interface
REQ-001 Parameter DATA_W, default 8, operand width in bits; legal range 2..32.
REQ-002 Parameter MUL_CYCLES, default 3, multiply latency in clock cycles; legal range 2..DATA_W.
REQ-003 Parameter OP_W, default 3, opcode width; fixed at 3 for this generation.
REQ-004 clk_i  input  1  clock, all state updates on rising edge.
REQ-005 reset_i  input  1  reset, asynchronous, active-high.
REQ-006 a_i  input  DATA_W  operand A, unsigned.
REQ-007 b_i  input  DATA_W  operand B, unsigned.
REQ-008 opcode_i  input  OP_W  operation select.
REQ-009 start_i  input  1  request; sampled only on edges where busy_o is 0.
REQ-010 result_o  output  2*DATA_W  registered result.
REQ-011 done_o  output  1  registered one-cycle completion pulse.
REQ-012 busy_o  output  1  registered; high while a multiply is in flight.
REQ-013 err_o  output  1  registered; qualifies done_o for an illegal opcode.

Function
REQ-014 Opcodes: 0 NOP, 1 ADD, 2 AND, 3 XOR, 4 MUL, 5 SUB; 6 and 7 illegal.
REQ-015 Request accepted at edge k iff start_i=1 and busy_o=0 before edge k; a, b and opcode are captured at edge k.
REQ-016 start_i with busy_o=1 is ignored; no done_o, no state change, no queuing.
REQ-017 Single-cycle ops (NOP, ADD, AND, XOR, SUB, illegal): done_o=1 in the cycle after edge k; busy_o stays 0.
REQ-018 Back-to-back single-cycle requests every cycle are supported; done_o then stays high continuously, one result per cycle.
REQ-019 ADD: result = zero-extended a+b; carry lands in bit DATA_W; upper bits zero.
REQ-020 AND, XOR: bitwise on DATA_W bits, zero-extended to 2*DATA_W.
REQ-021 SUB: result = (a-b) mod 2^(2*DATA_W), i.e. a borrow sign-extends across the upper half.
REQ-022 NOP: done_o=1, result_o unchanged.
REQ-023 Illegal opcode: done_o=1, err_o=1, result_o=0; err_o=0 on every other done_o.
REQ-024 MUL: full 2*DATA_W unsigned product; implementation style is free; latency is fixed.
REQ-025 MUL: busy_o=1 in the cycles after edges k .. k+MUL_CYCLES-2; done_o=1 with the product in the cycle after edge k+MUL_CYCLES-1; busy_o falls on that same edge.
REQ-026 FSM states IDLE and MUL_RUN.
  - IDLE -> MUL_RUN on an accepted MUL.
  - MUL_RUN -> IDLE when the cycle counter reaches MUL_CYCLES-1.
  - All other accepted ops stay in IDLE.
REQ-027 Cycle counter is ceil(log2(MUL_CYCLES)) bits; it clears on entry to MUL_RUN and does not wrap.
REQ-028 A start_i in the cycle where done_o for a MUL is high is accepted, because busy_o is already 0.
REQ-029 Operand changes on a_i/b_i during MUL_RUN do not affect the product.
REQ-030 result_o holds its last value between completions; it changes only on edges producing done_o.
REQ-031 done_o and err_o are single-cycle pulses per completed request.

Reset
REQ-032 reset_i=1 asynchronously forces result_o=0, done_o=0, busy_o=0, err_o=0, state IDLE, counter 0.
REQ-033 Reset during MUL_RUN aborts the operation; no done_o is produced for it after release.
REQ-034 The first request is accepted on the first rising edge with reset_i=0 and start_i=1.

Verification (DATA_W=8, MUL_CYCLES=3)
REQ-035 ADD a=0xFF b=0x01 -> next cycle done_o=1, result_o=0x0100, err_o=0.
REQ-036 SUB a=0x00 b=0x01 -> next cycle result_o=0xFFFF; SUB 0x05-0x03 -> 0x0002.
REQ-037 MUL a=0xFF b=0xFF at edge k, ADD request at edge k+1 -> busy_o high for 2 cycles, ADD ignored, done_o once after edge k+2 with 0xFE01.
REQ-038 Opcode 7 a=0x12 b=0x34 -> done_o=1, err_o=1, result_o=0x0000.
REQ-039 Four consecutive XOR requests 0xF0^0x0F, 0xAA^0x55, 0xFF^0xFF, 0x01^0x00 -> done_o high four cycles, results 0x00FF, 0x00FF, 0x0000, 0x0001.
REQ-040 Assert reset_i one cycle into a MUL -> all outputs 0 immediately (asynchronously); no done_o after release; a new ADD 0x02+0x03 then yields 0x0005.

Source files
------------

// File: rtl/tiny_alu_mc.sv
// Small multi-cycle ALU: single-cycle logic/arithmetic ops plus a fixed-latency
// unsigned multiply that holds busy_o while in flight.
module tiny_alu_mc #(
    parameter int DATA_W     = 8,
    parameter int MUL_CYCLES = 3,
    parameter int OP_W       = 3
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [DATA_W-1:0]     a_i,
    input  logic [DATA_W-1:0]     b_i,
    input  logic [OP_W-1:0]       opcode_i,
    input  logic                  start_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  done_o,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int RES_W = 2 * DATA_W;
    localparam int CNT_W = $clog2(MUL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] MUL_RUN = 1'b1;

    localparam logic [OP_W-1:0] OP_NOP = OP_W'(0);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AND = OP_W'(2);
    localparam logic [OP_W-1:0] OP_XOR = OP_W'(3);
    localparam logic [OP_W-1:0] OP_MUL = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(5);

    logic [0:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [DATA_W-1:0] mul_a;
    logic [DATA_W-1:0] mul_b;
    logic [RES_W-1:0]  a_ext;
    logic [RES_W-1:0]  b_ext;
    logic [RES_W-1:0]  product;
    logic [RES_W-1:0]  alu_res;
    logic              alu_err;

    assign a_ext    = RES_W'(a_i);
    assign b_ext    = RES_W'(b_i);
    assign cnt_next = cnt + CNT_W'(1);
    // Operands are latched at acceptance, so a_i/b_i may change freely meanwhile
    assign product  = RES_W'(mul_a) * RES_W'(mul_b);

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (opcode_i)
            OP_NOP:  alu_res = result_o;
            OP_ADD:  alu_res = a_ext + b_ext;
            OP_AND:  alu_res = a_ext & b_ext;
            OP_XOR:  alu_res = a_ext ^ b_ext;
            OP_SUB:  alu_res = a_ext - b_ext;
            OP_MUL:  alu_res = result_o;
            default: alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state    <= IDLE;
            cnt      <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            result_o <= '0;
            done_o   <= 1'b0;
            busy_o   <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            if (state == IDLE) begin
                if (start_i) begin
                    if (opcode_i == OP_MUL) begin
                        state  <= MUL_RUN;
                        busy_o <= 1'b1;
                        cnt    <= '0;
                        mul_a  <= a_i;
                        mul_b  <= b_i;
                    end else begin
                        done_o   <= 1'b1;
                        err_o    <= alu_err;
                        result_o <= alu_res;
                    end
                end
            end else begin
                // Counter stops at its last value on exit, so it never wraps
                cnt <= cnt_next;
                if (cnt_next == CNT_LAST) begin
                    state    <= IDLE;
                    busy_o   <= 1'b0;
                    done_o   <= 1'b1;
                    result_o <= product;
                end
            end
        end
    end

endmodule
